// File: rtl/dff_serial_tx_if.sv
// Word-input handshake for the serial transmitter.
// A word moves when in_valid and in_ready are both high at a rising clock edge. The producer must hold in_data and in_valid steady until that edge. in_ready does not depend on in_valid.
interface dff_serial_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/dff_serial_tx.sv
// Parallel-to-serial frame transmitter: start bit, MSB-first data, optional even parity, stop bit.
// Every output is decoded from registered state, so in_valid/in_data never reach an output combinationally.
module dff_serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              reset,
  dff_serial_tx_if.slave    in_if,
  output logic              tx_d,
  output logic              tx_frame,
  output logic              tx_done,
  output logic [2:0]        state_dbg
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    bit_idx;
  logic [WIDTH-1:0] shreg;
  logic             par;
  logic             cnt_last;
  logic             bit_last;

  assign cnt_last = (cnt == CW'(CLKS_PER_BIT - 1));
  assign bit_last = (bit_idx == IW'(WIDTH - 1));

  assign in_if.in_ready = (state == IDLE);
  assign tx_frame       = (state != IDLE);
  assign state_dbg      = state;

  always_comb begin
    tx_d = 1'b1;
    case (state)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg[WIDTH-1];
      PARITY:  tx_d = par;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state == IDLE) begin
        if (in_if.in_valid) begin
          state   <= START;
          shreg   <= in_if.in_data;
          // Parity is latched with the word so the later shifting cannot disturb it.
          par     <= ^in_if.in_data;
          cnt     <= '0;
          bit_idx <= '0;
        end
      end else if (!cnt_last) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
        case (state)
          START: state <= DATA;
          DATA: begin
            if (bit_last) begin
              bit_idx <= '0;
              state   <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg << 1;
            end
          end
          PARITY: state <= STOP;
          STOP: begin
            state   <= IDLE;
            tx_done <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
